mem_ctrl_param: RTL and testbench
=================================

MEM_CTRL_PARAM -- requirements
Module: mem_ctrl_param

Interface
REQ-001: Parameter DATA_W, default 8: data word width in bits; SHALL be a multiple of 8.
REQ-002: Parameter ADDR_W, default 8: address width in bits.
REQ-003: Parameter DEPTH, default 256: number of implemented words; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004: Parameter RD_LAT, default 1: read access latency in cycles; legal range 1..4.
REQ-005: Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006: Port rst, input, 1: reset, asynchronous and active-high.
REQ-007: Port req_valid, input, 1: request present.
REQ-008: Port req_ready, output, 1: controller can accept a request.
REQ-009: Port req_we, input, 1: 1 = write, 0 = read.
REQ-010: Port req_addr, input, ADDR_W: word address.
REQ-011: Port req_wdata, input, DATA_W: write data.
REQ-012: Port req_be, input, DATA_W/8: byte enables for writes; ignored on reads.
REQ-013: Port rsp_valid, output, 1: response present.
REQ-014: Port rsp_ready, input, 1: consumer accepts the response.
REQ-015: Port rsp_rdata, output, DATA_W: read data; zero for write responses and error responses.
REQ-016: Port rsp_err, output, 1: response error flag.
REQ-017: Port busy, output, 1: high in every state except IDLE.

Function
REQ-018: The controller SHALL implement FSM states IDLE, RD_WAIT, RESP.
REQ-019: req_ready SHALL be 1 only in IDLE; a request is accepted on any edge where req_valid && req_ready.
REQ-020: Accepted write to an in-range address SHALL update exactly the enabled bytes on the acceptance edge; the FSM SHALL then go IDLE -> RESP.
REQ-021: Accepted read SHALL capture the address, go IDLE -> RD_WAIT, and hold RD_WAIT for RD_LAT cycles (down-counter).
REQ-022: When the counter expires, the FSM SHALL load rsp_rdata and go RESP. rsp_valid is first high RD_LAT+1 cycles after the acceptance edge.
REQ-023: In RESP, rsp_valid SHALL stay 1 and rsp_rdata/rsp_err SHALL stay stable until rsp_valid && rsp_ready. The FSM then returns to IDLE on that edge.
REQ-024: Back-to-back issue is not overlapped. The next request SHALL be accepted no earlier than the cycle after the response handshake.
REQ-025: An address >= DEPTH SHALL produce a response with rsp_err=1 and rsp_rdata=0. Memory SHALL NOT be modified. Reads with such an address still observe RD_LAT.
REQ-026: A write with req_be all zero SHALL complete normally (rsp_err=0) with no memory change.
REQ-027: A read of an address written by the immediately preceding request SHALL return the new data.
REQ-028: Request inputs SHALL be ignored outside IDLE.

Reset
REQ-029: While rst=1, the controller SHALL hold: state=IDLE, req_ready=1 on deassertion, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, latency counter=0.
REQ-030: Reset mid-operation SHALL abort any pending read or response with no response emitted. A write already accepted stays committed.
REQ-031: Memory contents SHALL NOT be reset.

Configuration
REQ-032: When macro RAM_PARITY_EN is defined, the controller SHALL store one even-parity bit per byte, written with that byte.
REQ-033: With RAM_PARITY_EN defined, a read with any byte parity mismatch SHALL return rsp_err=1 together with the raw data.
REQ-034: Without RAM_PARITY_EN, no parity storage SHALL exist, and rsp_err SHALL reflect only the out-of-range condition.

Verification
REQ-035: Defaults. Write 0xA5 to addr 0x10 (be=1), then read 0x10 -> rsp_rdata=0xA5, rsp_err=0, rsp_valid 2 cycles after read acceptance.
REQ-036: DATA_W=32, RD_LAT=3. Write 0x11223344 be=0xF, then write 0xAABBCCDD be=0x5, then read -> 0x11BB33DD, rsp_valid 4 cycles after acceptance.
REQ-037: DEPTH=200. Write 0xFF to addr 200 -> rsp_err=1. Read addr 200 -> rsp_err=1 with rsp_rdata=0. Read addr 199 -> unchanged contents.
REQ-038: Read response with rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable throughout; req_ready=0 until the handshake edge.
REQ-039: Assert rst during RD_WAIT -> rsp_valid stays 0, busy=0 immediately. A subsequent read of a previously written address returns the stored data.
REQ-040: With RAM_PARITY_EN, write 0x3C, flip the stored parity bit via hierarchical deposit, then read -> rsp_err=1, rsp_rdata=0x3C.

Source files
------------

// File: rtl/mem_ctrl_param.sv
// mem_ctrl_param: word memory behind a valid/ready request/response FSM (IDLE/RD_WAIT/RESP).
// Define RAM_PARITY_EN to store one even-parity bit per byte and flag mismatches on reads.
module mem_ctrl_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              oor_q, oor_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              accept, wr_en, req_oor, rd_perr;
  logic [IDX_W-1:0]  widx, ridx;
  logic [DATA_W-1:0] rd_word;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign accept  = req_valid && req_ready;
  assign req_oor = ({1'b0, req_addr} >= DEPTH_L);
  assign wr_en   = accept && req_we && !req_oor;
  assign widx    = req_addr[IDX_W-1:0];
  assign ridx    = addr_q[IDX_W-1:0];
  assign rd_word = mem_q[ridx];

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];

  always_comb begin
    rd_perr = 1'b0;
    for (int b = 0; b < NB; b++)
      rd_perr = rd_perr | (^{rd_word[8*b +: 8], par_q[ridx][b]});
  end
`else
  assign rd_perr = 1'b0;
`endif

  // Storage is deliberately outside the reset domain; committed writes survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) begin
          mem_q[widx][8*b +: 8] <= req_wdata[8*b +: 8];
`ifdef RAM_PARITY_EN
          par_q[widx][b] <= ^req_wdata[8*b +: 8];
`endif
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    oor_d   = oor_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_we) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = req_oor;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = 3'(RD_LAT);
            addr_d  = req_addr;
            oor_d   = req_oor;
          end
        end
      end
      // Counting down to zero puts the first rsp_valid RD_LAT+1 edges after acceptance.
      RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
          rdata_d = oor_q ? '0 : rd_word;
          err_d   = oor_q ? 1'b1 : rd_perr;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      oor_q   <= oor_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_ctrl_param.sv
// Bench for mem_ctrl_param (DATA_W=32, DEPTH=200, RD_LAT=3): vector table plus corner sequences.
// Define RAM_PARITY_EN for both files to include the parity-corruption sequence.
module tb_mem_ctrl_param;
  localparam int DW = 32, AW = 8, DEPTH = 200, LAT = 3, NB = DW / 8, NV = 17;

  logic          clk = 1'b0, rst = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NB-1:0] req_be = '0;
  logic          req_ready, rsp_valid, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;

  mem_ctrl_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [NB-1:0] be;
    logic [DW-1:0] rdata;
    logic          err;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } exp_t;

  exp_t sb[$];
  vec_t vt[NV];
  int   n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic [NB-1:0] be, input logic [DW-1:0] exp_rd, input logic exp_err);
    int t = 0;
    while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
    check("req_ready before issue", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    sb.push_back('{rdata: exp_rd, err: exp_err, lat: (we ? 0 : LAT + 1)});
  endtask

  task automatic recv(input string tag, input int stall, input bit poke);
    exp_t e;
    int lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, " latency"}, 64'(lat), 64'(e.lat));
    check({tag, " rdata"}, 64'(rsp_rdata), 64'(e.rdata));
    check({tag, " err"}, 64'(rsp_err), 64'(e.err));
    check({tag, " busy in RESP"}, 64'(busy), 64'd1);
    if (poke) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h30; req_wdata = 32'h99; req_be = '1;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, " stall valid"}, 64'(rsp_valid), 64'd1);
      check({tag, " stall rdata"}, 64'(rsp_rdata), 64'(e.rdata));
      check({tag, " stall err"}, 64'(rsp_err), 64'(e.err));
      check({tag, " stall req_ready"}, 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0; req_we = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, " valid after handshake"}, 64'(rsp_valid), 64'd0);
    check({tag, " ready after handshake"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    vt[0]  = '{1'b1, 8'h10, 32'h0000_0000, 4'hF, 32'h0, 1'b0};
    vt[1]  = '{1'b1, 8'h10, 32'h0000_00A5, 4'h1, 32'h0, 1'b0};
    vt[2]  = '{1'b0, 8'h10, 32'h0,         4'h0, 32'h0000_00A5, 1'b0};
    vt[3]  = '{1'b1, 8'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
    vt[4]  = '{1'b1, 8'h20, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0};
    vt[5]  = '{1'b0, 8'h20, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vt[6]  = '{1'b1, 8'hC7, 32'h1234_5678, 4'hF, 32'h0, 1'b0};
    vt[7]  = '{1'b1, 8'hC8, 32'h0000_00FF, 4'hF, 32'h0, 1'b1};
    vt[8]  = '{1'b0, 8'hC8, 32'h0,         4'h0, 32'h0, 1'b1};
    vt[9]  = '{1'b0, 8'hC7, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
    vt[10] = '{1'b1, 8'h20, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
    vt[11] = '{1'b0, 8'h20, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vt[12] = '{1'b1, 8'hFF, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b1};
    vt[13] = '{1'b0, 8'hFF, 32'h0,         4'h0, 32'h0, 1'b1};
    vt[14] = '{1'b1, 8'h00, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    vt[15] = '{1'b0, 8'h00, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vt[16] = '{1'b1, 8'h30, 32'h0000_0055, 4'hF, 32'h0, 1'b0};

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("reset rsp_err", 64'(rsp_err), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset req_ready", 64'(req_ready), 64'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("post-reset req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < NV; i++) begin
      send(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].rdata, vt[i].err);
      recv($sformatf("vec%0d", i), 0, 1'b0);
    end

    // Stalled response: outputs hold, a request presented meanwhile is ignored
    send(1'b0, 8'h30, '0, '0, 32'h55, 1'b0);
    recv("stall", 5, 1'b1);
    send(1'b0, 8'h30, '0, '0, 32'h55, 1'b0);
    recv("ignored write", 0, 1'b0);

    // Reset during RD_WAIT aborts the read
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rd_wait busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort rsp_valid", 64'(rsp_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort no response", 64'(rsp_valid), 64'd0);
    end
    #2 rst = 1'b0;
    send(1'b0, 8'h10, '0, '0, 32'hA5, 1'b0);
    recv("read after abort", 0, 1'b0);

    // Accepted write survives a reset in RESP
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h40; req_wdata = 32'h0000_0077; req_be = '1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    check("write resp before reset", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("write resp dropped", 64'(rsp_valid), 64'd0);
    @(posedge clk); #3 rst = 1'b0;
    send(1'b0, 8'h40, '0, '0, 32'h77, 1'b0);
    recv("write committed", 0, 1'b0);

`ifdef RAM_PARITY_EN
    send(1'b1, 8'h50, 32'h0000_003C, 4'hF, 32'h0, 1'b0);
    recv("parity write", 0, 1'b0);
    dut.par_q[80][0] = ~dut.par_q[80][0];
    send(1'b0, 8'h50, '0, '0, 32'h3C, 1'b1);
    recv("parity error", 0, 1'b0);
`endif

    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard leftover: got %0d expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
